// File: rtl/pwm_ctrl_gen.sv
// pwm_ctrl_gen: programmable PWM source driving current_switch.ctrl.
// Period and high-time come in through a valid/ready config port. They are
// double-buffered and only take effect at a period boundary, or from IDLE.
module pwm_ctrl_gen #(
    parameter int unsigned CNT_WIDTH      = 16,
    parameter int unsigned DEFAULT_PERIOD = 100,
    parameter int unsigned DEFAULT_HIGH   = 50,
    parameter int unsigned CYC_WIDTH      = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 cfg_valid,
    output logic                 cfg_ready,
    input  logic [CNT_WIDTH-1:0] cfg_period,
    input  logic [CNT_WIDTH-1:0] cfg_high,
    output logic                 ctrl,
    output logic                 period_start,
    output logic [CYC_WIDTH-1:0] cycles
);

    localparam logic [CNT_WIDTH-1:0] P_DEF_PERIOD = CNT_WIDTH'(DEFAULT_PERIOD);
    localparam logic [CNT_WIDTH-1:0] P_DEF_HIGH   =
        CNT_WIDTH'((DEFAULT_HIGH > DEFAULT_PERIOD) ? DEFAULT_PERIOD : DEFAULT_HIGH);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t                 r_state;
    logic [CNT_WIDTH-1:0]   r_cnt;
    logic [CNT_WIDTH-1:0]   r_act_period;
    logic [CNT_WIDTH-1:0]   r_act_high;
    logic [CNT_WIDTH-1:0]   r_pend_period;
    logic [CNT_WIDTH-1:0]   r_pend_high;
    logic                   r_pend_full;
    logic                   r_cfg_ready;
    logic                   r_ctrl;
    logic                   r_period_start;
    logic [CYC_WIDTH-1:0]   r_cycles;

    logic [CNT_WIDTH-1:0]   w_san_period;
    logic [CNT_WIDTH-1:0]   w_san_high;
    logic                   w_take;
    logic                   w_boundary;
    logic                   w_apply;
    logic [CNT_WIDTH-1:0]   w_act_period_nxt;
    logic [CNT_WIDTH-1:0]   w_act_high_nxt;
    logic [CNT_WIDTH-1:0]   w_cnt_inc;

    // Sanitise incoming config and decide when the pending buffer is applied
    always_comb begin
        w_san_period     = (cfg_period == '0) ? CNT_WIDTH'(1) : cfg_period;
        w_san_high       = (cfg_high > w_san_period) ? w_san_period : cfg_high;
        w_take           = cfg_valid && r_cfg_ready;
        w_boundary       = (r_cnt == (r_act_period - CNT_WIDTH'(1)));
        // IDLE applies unconditionally; RUN only at a boundary while enabled
        w_apply          = r_pend_full && ((r_state == IDLE) || (en && w_boundary));
        w_act_period_nxt = w_apply ? r_pend_period : r_act_period;
        w_act_high_nxt   = w_apply ? r_pend_high   : r_act_high;
        w_cnt_inc        = r_cnt + CNT_WIDTH'(1);
    end

    // Config buffering, run/idle FSM, tick counter and registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state        <= IDLE;
            r_cnt          <= '0;
            r_act_period   <= P_DEF_PERIOD;
            r_act_high     <= P_DEF_HIGH;
            r_pend_period  <= '0;
            r_pend_high    <= '0;
            r_pend_full    <= 1'b0;
            r_cfg_ready    <= 1'b1;
            r_ctrl         <= 1'b0;
            r_period_start <= 1'b0;
            r_cycles       <= '0;
        end else begin
            r_act_period <= w_act_period_nxt;
            r_act_high   <= w_act_high_nxt;

            // A transfer needs cfg_ready=1, which implies the buffer is empty,
            // so a load and an apply never coincide.
            if (w_apply) begin
                r_pend_full <= 1'b0;
            end else if (w_take) begin
                r_pend_period <= w_san_period;
                r_pend_high   <= w_san_high;
                r_pend_full   <= 1'b1;
            end

            // cfg_ready reopens one edge after the buffer has been emptied
            if (w_take) begin
                r_cfg_ready <= 1'b0;
            end else if (!r_pend_full && !r_cfg_ready) begin
                r_cfg_ready <= 1'b1;
            end

            case (r_state)
                IDLE: begin
                    r_cnt <= '0;
                    if (en) begin
                        r_state        <= RUN;
                        r_period_start <= 1'b1;
                        r_cycles       <= r_cycles + CYC_WIDTH'(1);
                        r_ctrl         <= (w_act_high_nxt != '0);
                    end else begin
                        r_period_start <= 1'b0;
                        r_ctrl         <= 1'b0;
                    end
                end
                RUN: begin
                    if (!en) begin
                        r_state        <= IDLE;
                        r_cnt          <= '0;
                        r_period_start <= 1'b0;
                        r_ctrl         <= 1'b0;
                    end else if (w_boundary) begin
                        r_cnt          <= '0;
                        r_period_start <= 1'b1;
                        r_cycles       <= r_cycles + CYC_WIDTH'(1);
                        r_ctrl         <= (w_act_high_nxt != '0);
                    end else begin
                        r_cnt          <= w_cnt_inc;
                        r_period_start <= 1'b0;
                        r_ctrl         <= (w_cnt_inc < r_act_high);
                    end
                end
                default: begin
                    r_state        <= IDLE;
                    r_cnt          <= '0;
                    r_period_start <= 1'b0;
                    r_ctrl         <= 1'b0;
                end
            endcase
        end
    end

    assign cfg_ready    = r_cfg_ready;
    assign ctrl         = r_ctrl;
    assign period_start = r_period_start;
    assign cycles       = r_cycles;

endmodule

// File: tb/tb_pwm_ctrl_gen.sv
// Testbench for pwm_ctrl_gen: directed sequences with closed-form expected
// waveforms plus a table of hand-computed per-edge vectors.
module tb_pwm_ctrl_gen;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [15:0] cfg_period;
    logic [15:0] cfg_high;
    logic        ctrl;
    logic        period_start;
    logic [31:0] cycles;

    int unsigned n_checks;
    int unsigned n_err;

    typedef struct {
        logic        rst_n;
        logic        en;
        logic        v;
        logic [15:0] per;
        logic [15:0] hi;
        logic        e_ctrl;
        logic        e_ps;
        logic        e_rdy;
        int unsigned e_cyc;
    } vec_t;

    vec_t tbl[$];

    pwm_ctrl_gen #(
        .CNT_WIDTH      (16),
        .DEFAULT_PERIOD (100),
        .DEFAULT_HIGH   (50),
        .CYC_WIDTH      (32)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (en),
        .cfg_valid    (cfg_valid),
        .cfg_ready    (cfg_ready),
        .cfg_period   (cfg_period),
        .cfg_high     (cfg_high),
        .ctrl         (ctrl),
        .period_start (period_start),
        .cycles       (cycles)
    );

    // 10-unit clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int unsigned act, input int unsigned exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_outs(input string name, input bit e_ctrl, input bit e_ps,
                            input bit e_rdy, input int unsigned e_cyc);
        chk({name, ".ctrl"}, 32'(ctrl), 32'(e_ctrl));
        chk({name, ".period_start"}, 32'(period_start), 32'(e_ps));
        chk({name, ".cfg_ready"}, 32'(cfg_ready), 32'(e_rdy));
        chk({name, ".cycles"}, cycles, e_cyc);
    endtask

    // Steady-state waveform: cnt0 is the counter before the first edge, an
    // IDLE->RUN start behaves like a boundary from cnt0=per-1.
    task automatic expect_run(input string name, input int n, input int per, input int high,
                              input int cnt0, input int cyc0, input bit rdy);
        int c;
        for (int i = 1; i <= n; i++) begin
            step();
            c = (cnt0 + i) % per;
            chk_outs($sformatf("%s[%0d]", name, i), c < high, c == 0, rdy,
                     int'(cyc0 + (cnt0 + i) / per));
        end
    endtask

    function automatic vec_t mk(input bit r, input bit e, input bit v, input int per,
                                input int hi, input bit c, input bit ps, input bit rdy,
                                input int cyc);
        vec_t t;
        t.rst_n  = r;
        t.en     = e;
        t.v      = v;
        t.per    = 16'(per);
        t.hi     = 16'(hi);
        t.e_ctrl = c;
        t.e_ps   = ps;
        t.e_rdy  = rdy;
        t.e_cyc  = cyc;
        return t;
    endfunction

    initial begin
        n_checks   = 0;
        n_err      = 0;
        rst_n      = 1'b0;
        en         = 1'b0;
        cfg_valid  = 1'b0;
        cfg_period = '0;
        cfg_high   = '0;

        // Reset state, then idle with en=0
        step();
        step();
        chk_outs("reset", 0, 0, 1, 0);
        rst_n = 1'b1;
        step();
        chk_outs("idle", 0, 0, 1, 0);

        // Default waveform: 50 high / 50 low, cycles=3 after 300 ticks
        en = 1'b1;
        expect_run("dflt", 300, 100, 50, 99, 0, 1);
        expect_run("dflt2", 11, 100, 50, 99, 3, 1);

        // Config mid-period at cnt=10; further requests ignored while busy
        cfg_valid  = 1'b1;
        cfg_period = 16'd10;
        cfg_high   = 16'd3;
        step();
        chk_outs("cfg_take", 1, 0, 0, 4);
        cfg_period = 16'd7;
        cfg_high   = 16'd7;
        expect_run("cfg_wait", 88, 100, 50, 11, 4, 0);
        cfg_valid = 1'b0;
        step();
        chk_outs("cfg_bound", 1, 1, 0, 5);
        expect_run("p10h3", 25, 10, 3, 0, 5, 1);

        // Degenerate configs, boundary handshake, handshake while en drops
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0));
        tbl.push_back(mk(1, 0, 1, 0, 5, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 0, 0, 0, 1, 1, 0, 1));
        tbl.push_back(mk(1, 1, 0, 0, 0, 1, 1, 1, 2));
        tbl.push_back(mk(1, 1, 0, 0, 0, 1, 1, 1, 3));
        tbl.push_back(mk(1, 1, 1, 8, 0, 1, 1, 0, 4));
        tbl.push_back(mk(1, 1, 0, 0, 0, 0, 1, 0, 5));
        for (int i = 0; i < 7; i++) tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0, 1, 5));
        tbl.push_back(mk(1, 1, 1, 4, 3, 0, 1, 0, 6));
        for (int i = 0; i < 7; i++) tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 6));
        tbl.push_back(mk(1, 1, 0, 0, 0, 1, 1, 0, 7));
        tbl.push_back(mk(1, 1, 0, 0, 0, 1, 0, 1, 7));
        tbl.push_back(mk(1, 1, 0, 0, 0, 1, 0, 1, 7));
        tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0, 1, 7));
        tbl.push_back(mk(1, 1, 0, 0, 0, 1, 1, 1, 8));
        tbl.push_back(mk(1, 1, 0, 0, 0, 1, 0, 1, 8));
        tbl.push_back(mk(1, 0, 1, 6, 2, 0, 0, 0, 8));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 8));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 8));
        tbl.push_back(mk(1, 1, 0, 0, 0, 1, 1, 1, 9));
        tbl.push_back(mk(1, 1, 0, 0, 0, 1, 0, 1, 9));
        for (int i = 0; i < 4; i++) tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0, 1, 9));
        tbl.push_back(mk(1, 1, 0, 0, 0, 1, 1, 1, 10));

        for (int i = 0; i < tbl.size(); i++) begin
            rst_n      = tbl[i].rst_n;
            en         = tbl[i].en;
            cfg_valid  = tbl[i].v;
            cfg_period = tbl[i].per;
            cfg_high   = tbl[i].hi;
            step();
            chk_outs($sformatf("vec%0d", i), tbl[i].e_ctrl, tbl[i].e_ps,
                     tbl[i].e_rdy, tbl[i].e_cyc);
        end
        cfg_valid = 1'b0;

        // Reset from RUN, then drop en at cnt=20 and re-raise
        rst_n = 1'b0;
        en    = 1'b1;
        step();
        chk_outs("rst_run", 0, 0, 1, 0);
        rst_n = 1'b1;
        expect_run("pre_drop", 21, 100, 50, 99, 0, 1);
        en = 1'b0;
        step();
        chk_outs("en_drop", 0, 0, 1, 1);
        step();
        chk_outs("en_low", 0, 0, 1, 1);
        en = 1'b1;
        expect_run("restart", 5, 100, 50, 99, 1, 1);

        // Reset at cnt=30 with a pending config: config must be lost
        expect_run("to26", 22, 100, 50, 4, 2, 1);
        cfg_valid  = 1'b1;
        cfg_period = 16'd10;
        cfg_high   = 16'd3;
        step();
        chk_outs("pend_take", 1, 0, 0, 2);
        cfg_valid = 1'b0;
        expect_run("to30", 3, 100, 50, 27, 2, 0);
        rst_n = 1'b0;
        step();
        chk_outs("rst_pend", 0, 0, 1, 0);
        rst_n = 1'b1;
        expect_run("post_rst", 150, 100, 50, 99, 0, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/pwm_ctrl_gen.md
Name: pwm_ctrl_gen

Overview:
Digital PWM source that generates the `ctrl` gate signal consumed by current_switch. It sits directly upstream of the switch model in the emulator. Period and high-time are programmable in clock ticks through a valid/ready config port. New settings are double-buffered and take effect only at a period boundary, so the switch never sees a truncated or glitched pulse.

Parameters:
CNT_WIDTH, 16, width of the period/high-time registers and the tick counter
DEFAULT_PERIOD, 100, period in ticks after reset (must be >= 1)
DEFAULT_HIGH, 50, high-time in ticks after reset
CYC_WIDTH, 32, width of the completed-period counter

Ports:
clk  in  1  emulator clock; all logic on rising edge
rst_n  in  1  reset, synchronous, active-low
en  in  1  run enable; sampled every edge
cfg_valid  in  1  config request
cfg_ready  out  1  config slot free
cfg_period  in  CNT_WIDTH  requested period in ticks
cfg_high  in  CNT_WIDTH  requested high-time in ticks
ctrl  out  1  PWM output to current_switch.ctrl
period_start  out  1  one-cycle pulse on the first tick of every period
cycles  out  CYC_WIDTH  number of periods started since reset; wraps

Behaviour:
- All outputs are registered. Reset applies on any edge with rst_n=0, including mid-period.
- Reset values:
  - ctrl=0, period_start=0, cycles=0, cfg_ready=1.
  - State=IDLE, cnt=0.
  - act_period=DEFAULT_PERIOD, act_high=DEFAULT_HIGH.
  - Pending buffer empty; any pending config is discarded.
- Config handshake:
  - A transfer occurs on an edge where cfg_valid && cfg_ready.
  - The transfer loads pend_period/pend_high, sets pend_full, and clears cfg_ready.
  - cfg_ready returns to 1 on the edge after the pending buffer is applied.
  - Inputs are ignored while cfg_ready=0.
- Sanitising, done at load time:
  - cfg_period=0 is stored as 1.
  - cfg_high>period is stored as period.
- States: IDLE, RUN.
- IDLE:
  - ctrl=0, cnt=0, period_start=0.
  - If pend_full, the pending config is applied to act_* on the next edge and pend_full clears.
  - en=1 moves to RUN on the next edge.
- IDLE->RUN edge:
  - cnt=0, period_start=1, cycles+=1.
  - ctrl=(0<act_high), using the act_* value valid after that same edge. This includes a pending config applied on that edge.
- RUN, each edge with en=1:
  - If cnt==act_period-1 (boundary): cnt=0, period_start=1, cycles+=1.
  - At a boundary with pend_full set, the pending config is applied to act_* before ctrl is evaluated, and pend_full clears.
  - Otherwise: cnt+=1, period_start=0.
  - ctrl is registered as (cnt_next < act_high_next), so ctrl is high for exactly act_high ticks starting at period_start.
- Output extremes:
  - act_high=0 gives ctrl constantly 0.
  - act_high=act_period gives ctrl constantly 1.
  - act_period=1 gives period_start high every cycle.
- RUN with en=0 sampled: next edge goes to IDLE with ctrl=0, cnt=0, period_start=0. The partial period is abandoned and no cycles increment occurs. pend_full is kept.
- Simultaneous events:
  - A handshake on a boundary edge does not affect that boundary; it applies at the following boundary.
  - A handshake on the same edge that en drops is accepted; it is applied from IDLE on the following edge.
- cycles wraps from 2^CYC_WIDTH-1 to 0 silently.
- Widths: cnt and act_* are CNT_WIDTH unsigned. The comparison is unsigned. No overflow is possible because cnt < act_period <= 2^CNT_WIDTH-1.

Test Plan:
- Reset, en=1, defaults: ctrl is high for 50 ticks then low for 50, period_start every 100 ticks, cycles=3 after 300 ticks. The first ctrl=1 coincides with the first period_start.
- In RUN at cnt=10, send cfg (period=10, high=3): cfg_ready=0 until the boundary at cnt=99. The next period is 3 high / 7 low. cfg_ready=1 one edge after that boundary.
- Send cfg (period=0, high=5): stored as period 1, high 1; ctrl stays 1 and period_start stays 1 every cycle. Then send cfg (period=8, high=0): ctrl stays 0.
- Send cfg on the exact boundary edge (cnt=act_period-1): the old waveform repeats for one more full period, then the new one applies.
- Drop en at cnt=20: ctrl=0 next edge and cycles is unchanged. Re-raise en: the period restarts at cnt=0 with period_start=1.
- Assert rst_n=0 for 1 cycle at cnt=30 with a pending cfg: all outputs return to reset values, the pending cfg is lost, cfg_ready=1, and the DEFAULT_PERIOD/DEFAULT_HIGH waveform resumes when en=1.
